hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit.sv | 116 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Load-use / multicycle stall detection and EX-operand forwarding for an in-order
// ID/EX/MEM/WB pipeline. Bookkeeping entries mirror what sits in EX, MEM and WB.
module hazard_fwd_unit #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int MC_LAT  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NUM_SRC*AW-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]     id_rs_used,
    input  logic [AW-1:0]          id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_is_load,
    input  logic                   id_is_mc,
    input  logic                   flush,
    output logic                   stall,
    output logic                   ex_busy,
    output logic [2*NUM_SRC-1:0]   fwd_sel,
    output logic                   ex_valid,
    output logic                   wb_valid,
    output logic [AW-1:0]          wb_rd
);

    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

    typedef struct packed {
        logic                  valid;
        logic [NUM_SRC*AW-1:0] rs;
        logic [NUM_SRC-1:0]    rs_used;
        logic [AW-1:0]         rd;
        logic                  regwrite;
        logic                  is_load;
    } ex_entry_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          regwrite;
    } late_entry_t;

    ex_entry_t   ex_q;
    late_entry_t mem_q;
    late_entry_t wb_q;
    logic [3:0]  mc_cnt;
    logic        load_use;
    logic        issue;

    // A load in EX whose result an ID source needs cannot be forwarded in time.
    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_q.valid && ex_q.is_load && ex_q.regwrite && (ex_q.rd != '0) &&
                id_rs_used[i] && (id_rs[i*AW +: AW] == ex_q.rd))
                load_use = 1'b1;
        end
    end

    assign ex_busy = (mc_cnt != 4'd0);
    assign stall   = id_valid && (load_use || ex_busy) && !flush;
    assign issue   = id_valid && !stall && !flush;

    // MEM match outranks WB match since it carries the younger value.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_q.valid && ex_q.rs_used[i]) begin
                if (mem_q.valid && mem_q.regwrite && (mem_q.rd != '0) &&
                    (mem_q.rd == ex_q.rs[i*AW +: AW]))
                    fwd_sel[2*i +: 2] = 2'b10;
                else if (wb_q.valid && wb_q.regwrite && (wb_q.rd != '0) &&
                         (wb_q.rd == ex_q.rs[i*AW +: AW]))
                    fwd_sel[2*i +: 2] = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            mc_cnt <= 4'd0;
        end else begin
            wb_q <= mem_q;
            if (ex_busy)
                mem_q <= '0;
            else
                mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};

            // A busy EX holds its entry; a flush discards it even mid-multicycle.
            if (flush)
                ex_q <= '0;
            else if (!ex_busy) begin
                if (issue)
                    ex_q <= '{valid: 1'b1, rs: id_rs, rs_used: id_rs_used, rd: id_rd,
                              regwrite: id_regwrite, is_load: id_is_load};
                else
                    ex_q <= '0;
            end

            if (flush)
                mc_cnt <= 4'd0;
            else if (ex_busy)
                mc_cnt <= mc_cnt - 4'd1;
            else if (issue && id_is_mc)
                mc_cnt <= MC_LOAD;
        end
    end

    assign ex_valid = ex_q.valid;
    assign wb_valid = wb_q.valid;
    assign wb_rd    = wb_q.rd;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: each cycle's expected outputs are queued by the
// driver and checked by an independent negedge monitor.
module tb_hazard_fwd_unit;

    localparam int NUM_SRC = 2;
    localparam int AW      = 5;
    localparam int MC_LAT  = 4;
    localparam int W       = 13;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  id_valid;
    logic [NUM_SRC*AW-1:0] id_rs;
    logic [NUM_SRC-1:0]    id_rs_used;
    logic [AW-1:0]         id_rd;
    logic                  id_regwrite;
    logic                  id_is_load;
    logic                  id_is_mc;
    logic                  flush;
    logic                  stall;
    logic                  ex_busy;
    logic [2*NUM_SRC-1:0]  fwd_sel;
    logic                  ex_valid;
    logic                  wb_valid;
    logic [AW-1:0]         wb_rd;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .MC_LAT(MC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_is_mc(id_is_mc), .flush(flush),
        .stall(stall), .ex_busy(ex_busy), .fwd_sel(fwd_sel), .ex_valid(ex_valid),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                         input logic [1:0] used, input logic [AW-1:0] rd, input logic rw,
                         input logic ld, input logic mc, input logic fl);
        id_valid    = v;
        id_rs       = {rs1, rs0};
        id_rs_used  = used;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        id_is_mc    = mc;
        flush       = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // wb_rd is only meaningful while wb_valid is expected high.
    task automatic expect_out(input string nm, input logic st, input logic bz,
                              input logic [3:0] fw, input logic exv, input logic wbv,
                              input logic [AW-1:0] wrd);
        exp_q.push_back({st, bz, fw, exv, wbv, wrd});
        mask_q.push_back({8'hFF, wbv ? 5'h1F : 5'h00});
        name_q.push_back(nm);
    endtask

    task automatic expect_reset(input string nm);
        exp_q.push_back('0);
        mask_q.push_back('1);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e, m, act;
        string nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            m   = mask_q.pop_front();
            nm  = name_q.pop_front();
            act = {stall, ex_busy, fwd_sel, ex_valid, wb_valid, wb_rd};
            n_cmp++;
            if ((act & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL %s: stall,busy,fwd,exv,wbv,wbrd got %b %b %b %b %b %0d want %b %b %b %b %b %0d",
                         nm, act[12], act[11], act[10:7], act[6], act[5], act[4:0] & m[4:0],
                         e[12], e[11], e[10:7], e[6], e[5], e[4:0] & m[4:0]);
            end
        end
    end

    initial begin
        #60000;
        n_bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        idle();
        tick(); expect_reset("reset_hold");
        tick(); rst_n = 1'b1; idle(); expect_out("reset_release", 0, 0, 4'b0000, 0, 0, 0);

        // Back-to-back forwarding from MEM then WB
        tick(); drive(1, 1, 2, 2'b11, 5, 1, 0, 0, 0); expect_out("a1_issue_add", 0, 0, 4'b0000, 0, 0, 0);
        tick(); drive(1, 5, 3, 2'b11, 6, 1, 0, 0, 0); expect_out("a2_add_in_ex", 0, 0, 4'b0000, 1, 0, 0);
        tick(); drive(1, 4, 5, 2'b11, 8, 1, 0, 0, 0); expect_out("a3_fwd_mem_src0", 0, 0, 4'b0010, 1, 0, 0);
        tick(); idle(); expect_out("a4_fwd_wb_src1", 0, 0, 4'b0100, 1, 1, 5);
        tick(); idle(); expect_out("a5_wb_sub", 0, 0, 4'b0000, 0, 1, 6);
        tick(); idle(); expect_out("a6_wb_or", 0, 0, 4'b0000, 0, 1, 8);

        // Load-use: one stall cycle, then WB forward
        tick(); drive(1, 2, 0, 2'b01, 7, 1, 1, 0, 0); expect_out("b1_issue_load", 0, 0, 4'b0000, 0, 0, 0);
        tick(); drive(1, 7, 0, 2'b01, 9, 1, 0, 0, 0); expect_out("b2_load_use_stall", 1, 0, 4'b0000, 1, 0, 0);
        tick(); drive(1, 7, 0, 2'b01, 9, 1, 0, 0, 0); expect_out("b3_bubble_no_stall", 0, 0, 4'b0000, 0, 0, 0);
        tick(); idle(); expect_out("b4_fwd_wb_load", 0, 0, 4'b0001, 1, 1, 7);
        tick(); idle(); expect_out("b5_drain", 0, 0, 4'b0000, 0, 0, 0);
        tick(); idle(); expect_out("b6_wb_add", 0, 0, 4'b0000, 0, 1, 9);

        // x0 never hazards or forwards
        tick(); drive(1, 0, 0, 2'b00, 0, 1, 1, 0, 0); expect_out("c1_issue_load_x0", 0, 0, 4'b0000, 0, 0, 0);
        tick(); drive(1, 0, 0, 2'b11, 10, 1, 0, 0, 0); expect_out("c2_x0_no_stall", 0, 0, 4'b0000, 1, 0, 0);
        tick(); idle(); expect_out("c3_x0_no_fwd", 0, 0, 4'b0000, 1, 0, 0);
        tick(); idle(); expect_out("c4_wb_x0", 0, 0, 4'b0000, 0, 1, 0);
        tick(); idle(); expect_out("c5_wb_add", 0, 0, 4'b0000, 0, 1, 10);

        // Multicycle op then dependent op
        tick(); drive(1, 0, 0, 2'b00, 11, 1, 0, 0, 0); expect_out("d1_issue_add", 0, 0, 4'b0000, 0, 0, 0);
        tick(); drive(1, 11, 0, 2'b01, 12, 1, 0, 1, 0); expect_out("d2_issue_mc", 0, 0, 4'b0000, 1, 0, 0);
        tick(); drive(1, 12, 0, 2'b01, 13, 1, 0, 0, 0); expect_out("d3_busy1", 1, 1, 4'b0010, 1, 0, 0);
        tick(); drive(1, 12, 0, 2'b01, 13, 1, 0, 0, 0); expect_out("d4_busy2", 1, 1, 4'b0001, 1, 1, 11);
        tick(); drive(1, 12, 0, 2'b01, 13, 1, 0, 0, 0); expect_out("d5_busy3_mem_bubble", 1, 1, 4'b0000, 1, 0, 0);
        tick(); drive(1, 12, 0, 2'b01, 13, 1, 0, 0, 0); expect_out("d6_mc_last_cycle", 0, 0, 4'b0000, 1, 0, 0);
        tick(); idle(); expect_out("d7_dep_fwd_mem", 0, 0, 4'b0010, 1, 0, 0);
        tick(); idle(); expect_out("d8_wb_mc", 0, 0, 4'b0000, 0, 1, 12);
        tick(); idle(); expect_out("d9_wb_dep", 0, 0, 4'b0000, 0, 1, 13);

        // Flush during a multicycle op
        tick(); drive(1, 0, 0, 2'b00, 14, 1, 0, 0, 0); expect_out("e1_issue_add", 0, 0, 4'b0000, 0, 0, 0);
        tick(); drive(1, 0, 0, 2'b00, 15, 1, 0, 1, 0); expect_out("e2_issue_mc", 0, 0, 4'b0000, 1, 0, 0);
        tick(); drive(1, 0, 0, 2'b00, 16, 1, 0, 0, 1); expect_out("e3_flush_in_mc", 0, 1, 4'b0000, 1, 0, 0);
        tick(); drive(1, 0, 0, 2'b00, 16, 1, 0, 0, 0); expect_out("e4_after_flush", 0, 0, 4'b0000, 0, 1, 14);
        tick(); idle(); expect_out("e5_new_issue", 0, 0, 4'b0000, 1, 0, 0);
        tick(); idle(); expect_out("e6_mc_never_in_mem", 0, 0, 4'b0000, 0, 0, 0);
        tick(); idle(); expect_out("e7_wb_new", 0, 0, 4'b0000, 0, 1, 16);

        // Flush coinciding with a load-use hazard
        tick(); drive(1, 0, 0, 2'b00, 3, 1, 1, 0, 0); expect_out("g1_issue_load", 0, 0, 4'b0000, 0, 0, 0);
        tick(); drive(1, 3, 0, 2'b01, 4, 1, 0, 0, 1); expect_out("g2_flush_beats_hazard", 0, 0, 4'b0000, 1, 0, 0);
        tick(); idle(); expect_out("g3_nothing_issued", 0, 0, 4'b0000, 0, 0, 0);
        tick(); idle();

        // Asynchronous reset in the middle of a multicycle stall
        tick(); drive(1, 0, 0, 2'b00, 20, 1, 0, 0, 0); expect_out("f1_issue_add", 0, 0, 4'b0000, 0, 0, 0);
        tick(); drive(1, 0, 0, 2'b00, 21, 1, 0, 1, 0); expect_out("f2_issue_mc", 0, 0, 4'b0000, 1, 0, 0);
        tick(); drive(1, 21, 0, 2'b01, 22, 1, 0, 0, 0); expect_out("f3_stall_busy", 1, 1, 4'b0000, 1, 0, 0);
        tick(); drive(1, 21, 0, 2'b01, 22, 1, 0, 0, 0);
        #1 rst_n = 1'b0;
        expect_reset("f4_async_reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(); idle(); expect_out("f5_issued_after_reset", 0, 0, 4'b0000, 1, 0, 0);
        tick(); idle(); expect_out("f6_drain", 0, 0, 4'b0000, 0, 0, 0);
        tick(); idle(); expect_out("f7_wb_after_reset", 0, 0, 4'b0000, 0, 1, 22);

        tick();
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending checks want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
